// File: rtl/camera_st_pkg.sv
// Shared types for the camera capture front-end: FSM states, beat framing flags
// and the helper that sizes a FIFO entry (framing flags plus pixel data).
package camera_st_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    ACTIVE = 3'd2,
    SKIP   = 3'd3,
    DROP   = 3'd4
  } state_e;

  localparam int CTRL_W = 2;

  typedef struct packed {
    logic sop;
    logic eop;
  } beat_ctrl_t;

  function automatic int fifo_width(input int data_w);
    return data_w + CTRL_W;
  endfunction

endpackage

// File: rtl/camera_st_if.sv
// Avalon-ST style video stream bundle (ready latency 0) between the capture
// block and its downstream consumer.
interface camera_st_if #(
  parameter int W = 12
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;
  logic         sop;
  logic         eop;

  modport master (output data, output valid, output sop, output eop, input ready);
  modport slave  (input data, input valid, input sop, input eop, output ready);
endinterface

// File: rtl/camera_st_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on o_data whenever
// o_empty is low; o_count lets the writer keep a reserved slot.
module camera_st_fifo #(
  parameter  int WIDTH = 14,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign w_wr = i_push & (r_count != CW'(DEPTH));
  assign w_rd = i_pop & (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
endmodule

// File: rtl/camera_st_capture.sv
// Camera parallel-port capture: turns fval/lval timing into a framed video
// stream through a one-beat staging register and a backpressured FIFO.
module camera_st_capture
  import camera_st_pkg::*;
#(
  parameter int DATA_W      = 12,
  parameter int PIX_PER_CLK = 1,
  parameter int FIFO_DEPTH  = 64,
  parameter int DIM_W       = 12
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W*PIX_PER_CLK-1:0] i_cam_d,
  input  logic                          i_cam_fval,
  input  logic                          i_cam_lval,
  input  logic                          i_enable,
  input  logic [3:0]                    i_frame_skip,
  camera_st_if.master                   src,
  output logic [15:0]                   o_frame_count,
  output logic [DIM_W-1:0]              o_line_width,
  output logic [DIM_W-1:0]              o_frame_height,
  output logic                          o_overflow,
  input  logic                          i_overflow_clr
);
  localparam int PW = DATA_W * PIX_PER_CLK;
  localparam int FW = fifo_width(PW);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    beat_ctrl_t    ctrl;
    logic [PW-1:0] data;
  } beat_t;

  logic [PW-1:0]    r_cam_d;
  logic             r_fval, r_lval, r_fval_d, r_lval_d;
  state_e           r_state, w_next;
  logic [PW-1:0]    r_stage_data;
  logic             r_stage_sop, r_stage_vld, r_first;
  logic [3:0]       r_skip_cnt;
  logic [DIM_W-1:0] r_line_beats, r_lines;
  logic             w_rise, w_fall, w_beat, w_go, w_start, w_room;
  logic             w_close, w_hit, w_take, w_push, w_pop, w_empty, w_in_frame;
  logic [CW-1:0]    w_count;
  beat_t            w_push_beat, w_head;
  logic [FW-1:0]    w_fifo_out;

  // Input pipeline carries no reset so a reset mid-frame still sees the live fval level.
  always_ff @(posedge clk) begin
    r_cam_d  <= i_cam_d;
    r_fval   <= i_cam_fval;
    r_lval   <= i_cam_lval;
    r_fval_d <= r_fval;
    r_lval_d <= r_lval;
  end

  assign w_rise     = r_fval & ~r_fval_d;
  assign w_fall     = ~r_fval & r_fval_d;
  assign w_beat     = r_fval & r_lval;
  assign w_go       = i_enable & (r_skip_cnt == 4'd0);
  assign w_start    = (r_state == ARMED) & w_rise & w_go;
  assign w_in_frame = (r_state == ACTIVE) | (r_state == DROP);
  assign w_room     = w_count < CW'(FIFO_DEPTH - 1);
  assign w_hit      = (r_state == ACTIVE) & w_beat & r_stage_vld & ~w_room;
  assign w_take     = (w_start | (r_state == ACTIVE)) & w_beat & ~w_hit;
  assign w_close    = w_in_frame & w_fall & r_stage_vld;
  assign w_push     = (w_take & r_stage_vld) | w_close;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (!r_fval) w_next = ARMED;
      ARMED:  if (w_rise) w_next = w_go ? ACTIVE : SKIP;
      ACTIVE: begin
        if (w_fall)     w_next = ARMED;
        else if (w_hit) w_next = DROP;
      end
      SKIP, DROP: if (w_fall) w_next = ARMED;
      default: w_next = IDLE;
    endcase
  end

  // The staged beat is only pushed once its successor (or the frame end) shows up,
  // which is what lets the last beat of a frame carry eop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage_data   <= '0;
      r_stage_sop    <= 1'b0;
      r_stage_vld    <= 1'b0;
      r_first        <= 1'b0;
      r_skip_cnt     <= 4'd0;
      r_line_beats   <= '0;
      r_lines        <= '0;
      o_frame_count  <= 16'd0;
      o_line_width   <= '0;
      o_frame_height <= '0;
      o_overflow     <= 1'b0;
    end else begin
      if ((r_state == ARMED) && w_rise)
        r_skip_cnt <= (r_skip_cnt >= i_frame_skip) ? 4'd0 : r_skip_cnt + 4'd1;
      if (w_start) begin
        r_first      <= 1'b1;
        r_lines      <= w_beat ? DIM_W'(1) : '0;
        r_line_beats <= w_beat ? DIM_W'(1) : '0;
      end else if (w_in_frame && w_beat) begin
        if (!r_lval_d) begin
          r_lines      <= r_lines + DIM_W'(1);
          r_line_beats <= DIM_W'(1);
        end else begin
          r_line_beats <= r_line_beats + DIM_W'(1);
        end
      end
      if (w_take) begin
        r_stage_data <= r_cam_d;
        r_stage_sop  <= w_start | r_first;
        r_stage_vld  <= 1'b1;
        r_first      <= 1'b0;
      end
      if (w_close) begin
        r_stage_vld    <= 1'b0;
        o_frame_count  <= o_frame_count + 16'd1;
        o_line_width   <= r_line_beats;
        o_frame_height <= r_lines;
      end
      if (w_hit || ((r_state == DROP) && w_beat)) o_overflow <= 1'b1;
      else if (i_overflow_clr)                    o_overflow <= 1'b0;
    end
  end

  always_comb begin
    w_push_beat.ctrl.sop = r_stage_sop;
    w_push_beat.ctrl.eop = w_close;
    w_push_beat.data     = r_stage_data;
  end

  assign w_pop = ~w_empty & src.ready;

  camera_st_fifo #(
    .WIDTH(FW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_push_beat),
    .i_pop   (w_pop),
    .o_data  (w_fifo_out),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_head    = w_fifo_out;
  assign src.valid = ~w_empty;
  assign src.data  = w_head.data;
  assign src.sop   = w_head.ctrl.sop;
  assign src.eop   = w_head.ctrl.eop;
endmodule
